// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the four-master round-robin bus arbiter.
// Owner encoding, arbitration states and default bus widths.
package bus_arbiter_pkg;

  localparam int MASTER_COUNT       = 4;
  localparam int BUS_OWNER_WIDTH    = 2;
  localparam int WORD_ADDRESS_WIDTH = 30;
  localparam int WORD_DATA_WIDTH    = 32;

  typedef logic [BUS_OWNER_WIDTH-1:0] owner_t;

  localparam owner_t BUS_OWNER_MASTER0 = 2'd0;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'h0,
    STATE_GRANTED = 2'h1,
    STATE_BUSY    = 2'h2
  } arb_state_t;

endpackage

// File: rtl/bus_master_multiplexer.sv
// Owner-indexed select of the master-side access signals onto the shared bus.
// Only the owner's lane is read, so junk on other lanes never reaches the output.
module bus_master_multiplexer
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = WORD_ADDRESS_WIDTH,
  parameter int DATA_WIDTH = WORD_DATA_WIDTH
) (
  input  owner_t                                   owner,
  input  logic [MASTER_COUNT-1:0][ADDR_WIDTH-1:0]  master_address,
  input  logic [MASTER_COUNT-1:0]                  master_address_strobe_,
  input  logic [MASTER_COUNT-1:0]                  master_read_write,
  input  logic [MASTER_COUNT-1:0][DATA_WIDTH-1:0]  master_write_data,
  output logic [ADDR_WIDTH-1:0]                    owner_address,
  output logic                                     owner_address_strobe_,
  output logic                                     owner_read_write,
  output logic [DATA_WIDTH-1:0]                    owner_write_data
);

  assign owner_address         = master_address[owner];
  assign owner_address_strobe_ = master_address_strobe_[owner];
  assign owner_read_write      = master_read_write[owner];
  assign owner_write_data      = master_write_data[owner];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters sharing one slave bus.
// Ownership is held across an outstanding access and handed over with no dead cycle.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = WORD_ADDRESS_WIDTH,
  parameter int DATA_WIDTH = WORD_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_,
  input  logic                  master0_request_,
  input  logic [ADDR_WIDTH-1:0] master0_address,
  input  logic                  master0_address_strobe_,
  input  logic                  master0_read_write,
  input  logic [DATA_WIDTH-1:0] master0_write_data,
  output logic                  master0_grant_,
  input  logic                  master1_request_,
  input  logic [ADDR_WIDTH-1:0] master1_address,
  input  logic                  master1_address_strobe_,
  input  logic                  master1_read_write,
  input  logic [DATA_WIDTH-1:0] master1_write_data,
  output logic                  master1_grant_,
  input  logic                  master2_request_,
  input  logic [ADDR_WIDTH-1:0] master2_address,
  input  logic                  master2_address_strobe_,
  input  logic                  master2_read_write,
  input  logic [DATA_WIDTH-1:0] master2_write_data,
  output logic                  master2_grant_,
  input  logic                  master3_request_,
  input  logic [ADDR_WIDTH-1:0] master3_address,
  input  logic                  master3_address_strobe_,
  input  logic                  master3_read_write,
  input  logic [DATA_WIDTH-1:0] master3_write_data,
  output logic                  master3_grant_,
  input  logic                  bus_ready_,
  output logic [ADDR_WIDTH-1:0] slave_address,
  output logic                  slave_address_strobe_,
  output logic                  slave_read_write,
  output logic [DATA_WIDTH-1:0] slave_write_data
);

  owner_t     owner;
  arb_state_t state;

  logic [MASTER_COUNT-1:0]                 request;
  logic [MASTER_COUNT-1:0][ADDR_WIDTH-1:0] master_address;
  logic [MASTER_COUNT-1:0]                 master_address_strobe_;
  logic [MASTER_COUNT-1:0]                 master_read_write;
  logic [MASTER_COUNT-1:0][DATA_WIDTH-1:0] master_write_data;
  logic                                    owner_address_strobe_;
  logic                                    owner_request;
  logic                                    owner_strobe;
  logic                                    ready;
  logic                                    rr_found;
  owner_t                                  rr_winner;

  // Search owner+1, owner+2, owner+3, owner; the current owner always comes last.
  function automatic logic [BUS_OWNER_WIDTH:0] rr_search(input owner_t current,
                                                         input logic [MASTER_COUNT-1:0] req);
    owner_t cand;
    owner_t winner;
    logic   found;
    found  = 1'b0;
    winner = current;
    for (int k = 1; k <= MASTER_COUNT; k++) begin
      cand = current + owner_t'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    return {found, winner};
  endfunction

  assign request = ~{master3_request_, master2_request_, master1_request_, master0_request_};
  assign master_address = {master3_address, master2_address, master1_address, master0_address};
  assign master_address_strobe_ = {master3_address_strobe_, master2_address_strobe_,
                                   master1_address_strobe_, master0_address_strobe_};
  assign master_read_write = {master3_read_write, master2_read_write,
                              master1_read_write, master0_read_write};
  assign master_write_data = {master3_write_data, master2_write_data,
                              master1_write_data, master0_write_data};

  bus_master_multiplexer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .owner                  (owner),
    .master_address         (master_address),
    .master_address_strobe_ (master_address_strobe_),
    .master_read_write      (master_read_write),
    .master_write_data      (master_write_data),
    .owner_address          (slave_address),
    .owner_address_strobe_  (owner_address_strobe_),
    .owner_read_write       (slave_read_write),
    .owner_write_data       (slave_write_data)
  );

  assign owner_request           = request[owner];
  assign owner_strobe            = ~owner_address_strobe_;
  assign ready                   = ~bus_ready_;
  assign {rr_found, rr_winner}   = rr_search(owner, request);

  // A parked owner that is not requesting cannot put a strobe on the bus.
  assign slave_address_strobe_ = (owner_request || state == STATE_BUSY) ?
                                 owner_address_strobe_ : 1'b1;

  assign master0_grant_ = (owner != 2'd0);
  assign master1_grant_ = (owner != 2'd1);
  assign master2_grant_ = (owner != 2'd2);
  assign master3_grant_ = (owner != 2'd3);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      owner <= BUS_OWNER_MASTER0;
      state <= STATE_IDLE;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (rr_found) begin
            owner <= rr_winner;
            state <= STATE_GRANTED;
          end
        end
        STATE_GRANTED: begin
          if (owner_request && owner_strobe) begin
            if (!ready) state <= STATE_BUSY;
          end else if (!owner_request) begin
            if (rr_found) owner <= rr_winner;
            else          state <= STATE_IDLE;
          end
        end
        STATE_BUSY: begin
          if (ready) begin
            if (owner_request) begin
              state <= STATE_GRANTED;
            end else if (rr_found) begin
              owner <= rr_winner;
              state <= STATE_GRANTED;
            end else begin
              state <= STATE_IDLE;
            end
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized bench for bus_arbiter against a tenure/access reference model.
module tb_bus_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset_;
  logic [3:0] req_n, stb_n, rw;
  logic [AW-1:0] addr [4];
  logic [DW-1:0] wd [4];
  logic bus_ready_;
  logic g0, g1, g2, g3;
  logic [AW-1:0] slave_address;
  logic slave_address_strobe_, slave_read_write;
  logic [DW-1:0] slave_write_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the bus, whether the owner holds a tenure, whether an access is open.
  int m_owner;
  bit m_tenure;
  bit m_busy;

  always #5 clock = ~clock;

  bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset_(reset_),
    .master0_request_(req_n[0]), .master0_address(addr[0]), .master0_address_strobe_(stb_n[0]),
    .master0_read_write(rw[0]), .master0_write_data(wd[0]), .master0_grant_(g0),
    .master1_request_(req_n[1]), .master1_address(addr[1]), .master1_address_strobe_(stb_n[1]),
    .master1_read_write(rw[1]), .master1_write_data(wd[1]), .master1_grant_(g1),
    .master2_request_(req_n[2]), .master2_address(addr[2]), .master2_address_strobe_(stb_n[2]),
    .master2_read_write(rw[2]), .master2_write_data(wd[2]), .master2_grant_(g2),
    .master3_request_(req_n[3]), .master3_address(addr[3]), .master3_address_strobe_(stb_n[3]),
    .master3_read_write(rw[3]), .master3_write_data(wd[3]), .master3_grant_(g3),
    .bus_ready_(bus_ready_),
    .slave_address(slave_address), .slave_address_strobe_(slave_address_strobe_),
    .slave_read_write(slave_read_write), .slave_write_data(slave_write_data)
  );

  function automatic int rr_pick(input int cur, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      if (req[(cur + k) % 4]) return (cur + k) % 4;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = 0; m_tenure = 0; m_busy = 0;
  endtask

  task automatic m_update();
    logic [3:0] req;
    bit rdy, own_req, own_stb;
    int w;
    req = ~req_n;
    rdy = (bus_ready_ == 1'b0);
    own_req = req[m_owner];
    own_stb = (stb_n[m_owner] == 1'b0);
    w = rr_pick(m_owner, req);
    if (m_busy) begin
      if (rdy) begin
        m_busy = 0;
        if (!own_req) begin
          if (w >= 0) m_owner = w;
          else m_tenure = 0;
        end
      end
    end else if (m_tenure) begin
      if (own_req && own_stb) m_busy = !rdy;
      else if (!own_req) begin
        if (w >= 0) m_owner = w;
        else m_tenure = 0;
      end
    end else if (w >= 0) begin
      m_owner = w;
      m_tenure = 1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] grants();
    return {g3, g2, g1, g0};
  endfunction

  task automatic check_outputs(input string tag);
    logic [3:0] gexp;
    logic sexp;
    gexp = 4'b1111 & ~(4'b0001 << m_owner);
    sexp = (req_n[m_owner] == 1'b0 || m_busy) ? stb_n[m_owner] : 1'b1;
    check({tag, ".grant"}, {60'b0, grants()}, {60'b0, gexp});
    check({tag, ".strobe"}, {63'b0, slave_address_strobe_}, {63'b0, sexp});
    check({tag, ".bus"}, {1'b0, slave_address, slave_read_write, slave_write_data},
          {1'b0, addr[m_owner], rw[m_owner], wd[m_owner]});
  endtask

  // Called at a negedge after inputs are driven; returns at the following negedge.
  task automatic step(input string tag);
    #1 check_outputs({tag, ".pre"});
    @(posedge clock);
    m_update();
    #1 check_outputs(tag);
    @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    #2 reset_ = 1'b0;
    #1;
    check({tag, ".rst_grant"}, {60'b0, grants()}, 64'hE);
    check({tag, ".rst_strobe"}, {63'b0, slave_address_strobe_}, 64'h1);
    m_reset();
    @(negedge clock);
    reset_ = 1'b1;
  endtask

  initial begin
    reset_ = 1'b1; req_n = 4'hF; stb_n = 4'hF; rw = 4'h0; bus_ready_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr[i] = AW'(32'h100 * (i + 1));
      wd[i]   = 32'hA000_0000 + DW'(i);
    end
    m_reset();
    do_reset("reset");

    stb_n[0] = 1'b0;
    step("park");
    check("park.const", {63'b0, slave_address_strobe_}, 64'h1);
    stb_n[0] = 1'b1;

    addr[2] = 30'h0000_1234;
    req_n = 4'b1011;
    step("single");
    check("single.grant2", {60'b0, grants()}, 64'hB);
    check("single.addr", {34'b0, slave_address}, 64'h1234);
    req_n = 4'b1111;
    step("single.rel");

    req_n = 4'b1110;
    step("cont.own0");
    req_n = 4'b0101;
    step("cont.g1");
    check("cont.first", {60'b0, grants()}, 64'hD);
    req_n = 4'b0100;
    step("cont.hold1");
    req_n = 4'b0110;
    step("cont.g3");
    check("cont.second", {60'b0, grants()}, 64'h7);
    req_n = 4'b1110;
    step("cont.g0");
    check("cont.third", {60'b0, grants()}, 64'hE);

    req_n = 4'b1101;
    step("busy.own1");
    stb_n[1] = 1'b0;
    step("busy.start");
    req_n = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      step("busy.hold");
      check("busy.lock", {60'b0, grants()}, 64'hD);
    end
    bus_ready_ = 1'b0;
    step("busy.done");
    check("busy.handover", {60'b0, grants()}, 64'h7);
    stb_n = 4'hF; bus_ready_ = 1'b1;

    req_n = 4'b1010;
    step("wrap.g0");
    check("wrap.first", {60'b0, grants()}, 64'hE);
    req_n = 4'b1011;
    step("wrap.g2");
    check("wrap.second", {60'b0, grants()}, 64'hB);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(3) == 0) req_n[i] = ~req_n[i];
      for (int i = 0; i < 4; i++) begin
        if (req_n[i] == 1'b0 || i == m_owner) begin
          addr[i]  = AW'($urandom);
          wd[i]    = $urandom;
          rw[i]    = 1'($urandom_range(1));
          stb_n[i] = 1'($urandom_range(1));
        end else begin
          addr[i] = 'x; wd[i] = 'x; rw[i] = 1'bx; stb_n[i] = 1'bx;
        end
      end
      bus_ready_ = ($urandom_range(2) != 0);
      if (n == 200) do_reset("midreset");
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
